// File: rtl/noobs_pkg.sv
// rtl/noobs_pkg.sv - shared types and helpers for the 8-bit core
package noobs_pkg;

  localparam int ADDR_W = 12;

  localparam logic [1:0] MODE_IMP = 2'b00;
  localparam logic [1:0] MODE_IMM = 2'b01;
  localparam logic [1:0] MODE_ABS = 2'b10;
  localparam logic [1:0] MODE_ILL = 2'b11;

  typedef enum logic [1:0] {
    OPC  = 2'd0,
    OPR1 = 2'd1,
    OPR2 = 2'd2,
    HOLD = 2'd3
  } state_t;

  // Illegal opcodes are consumed as single bytes so fetch never stalls on them.
  function automatic logic [1:0] inst_len(input logic [1:0] mode);
    case (mode)
      MODE_IMM: inst_len = 2'd2;
      MODE_ABS: inst_len = 2'd3;
      default:  inst_len = 2'd1;
    endcase
  endfunction

endpackage

// File: rtl/idecode.sv
// rtl/idecode.sv - assembles opcode plus operand bytes into one decoded instruction
module idecode #(
  parameter int ADDR_W = noobs_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic [7:0]        inst_i,
  input  logic              inst_vld,
  input  logic [ADDR_W-1:0] fetch_pc,
  input  logic              branch,
  input  logic              exec_rdy,
  output logic              ifetch_en,
  output logic              dec_vld,
  output logic [3:0]        dec_op,
  output logic [1:0]        dec_reg,
  output logic [1:0]        dec_mode,
  output logic [7:0]        dec_imm,
  output logic [ADDR_W-1:0] dec_addr,
  output logic [ADDR_W-1:0] dec_pc,
  output logic [ADDR_W-1:0] dec_next_pc,
  output logic              dec_illegal
);
  import noobs_pkg::*;

  state_t            state;
  logic [7:0]        byte0;
  logic [7:0]        byte1;
  logic [ADDR_W-1:0] pc_q;

  logic              accept;
  logic              at_opc;
  logic [7:0]        cur_b0;
  logic [7:0]        cur_b1;
  logic [ADDR_W-1:0] cur_pc;
  logic [1:0]        cur_mode;
  logic              last_byte;

  assign ifetch_en = (state != HOLD) || exec_rdy;
  assign accept    = inst_vld && ifetch_en && !branch;
  assign at_opc    = (state == OPC) || (state == HOLD);

  // View of the instruction as it will look once this cycle's byte is captured.
  always_comb begin
    cur_b0    = at_opc ? inst_i : byte0;
    cur_pc    = at_opc ? fetch_pc : pc_q;
    cur_b1    = (state == OPR1) ? inst_i : byte1;
    cur_mode  = cur_b0[1:0];
    last_byte = 1'b0;
    case (state)
      OPC, HOLD: last_byte = (cur_mode == MODE_IMP) || (cur_mode == MODE_ILL);
      OPR1:      last_byte = (cur_mode == MODE_IMM);
      OPR2:      last_byte = 1'b1;
      default:   last_byte = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state       <= OPC;
      byte0       <= '0;
      byte1       <= '0;
      pc_q        <= '0;
      dec_vld     <= 1'b0;
      dec_op      <= '0;
      dec_reg     <= '0;
      dec_mode    <= '0;
      dec_imm     <= '0;
      dec_addr    <= '0;
      dec_pc      <= '0;
      dec_next_pc <= '0;
      dec_illegal <= 1'b0;
    end else if (branch) begin
      state   <= OPC;
      dec_vld <= 1'b0;
    end else if (accept) begin
      if (at_opc) begin
        byte0 <= inst_i;
        pc_q  <= fetch_pc;
      end
      if (state == OPR1) begin
        byte1 <= inst_i;
      end
      if (last_byte) begin
        state       <= HOLD;
        dec_vld     <= 1'b1;
        dec_op      <= cur_b0[7:4];
        dec_reg     <= cur_b0[3:2];
        dec_mode    <= cur_mode;
        dec_imm     <= (cur_mode == MODE_IMM) ? cur_b1 : 8'h00;
        dec_addr    <= (cur_mode == MODE_ABS) ? ADDR_W'({inst_i[3:0], cur_b1}) : '0;
        dec_pc      <= cur_pc;
        dec_next_pc <= cur_pc + ADDR_W'(inst_len(cur_mode));
        dec_illegal <= (cur_mode == MODE_ILL);
      end else begin
        state   <= (state == OPR1) ? OPR2 : OPR1;
        dec_vld <= 1'b0;
      end
    end else if ((state == HOLD) && exec_rdy) begin
      state   <= OPC;
      dec_vld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_idecode.sv
// tb/tb_idecode.sv - scoreboard bench for idecode with directed byte streams
module tb_idecode;

  localparam int AW = 12;

  typedef struct packed {
    logic [3:0]    op;
    logic [1:0]    rsel;
    logic [1:0]    mode;
    logic [7:0]    imm;
    logic [AW-1:0] addr;
    logic [AW-1:0] pc;
    logic [AW-1:0] npc;
    logic          ill;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_ = 1'b0;
  logic [7:0]    inst_i = 8'h00;
  logic          inst_vld = 1'b0;
  logic [AW-1:0] fetch_pc = '0;
  logic          branch = 1'b0;
  logic          exec_rdy = 1'b0;
  logic          ifetch_en;
  logic          dec_vld;
  logic [3:0]    dec_op;
  logic [1:0]    dec_reg;
  logic [1:0]    dec_mode;
  logic [7:0]    dec_imm;
  logic [AW-1:0] dec_addr;
  logic [AW-1:0] dec_pc;
  logic [AW-1:0] dec_next_pc;
  logic          dec_illegal;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  idecode #(.ADDR_W(AW)) dut (
    .clk(clk), .reset_(reset_), .inst_i(inst_i), .inst_vld(inst_vld),
    .fetch_pc(fetch_pc), .branch(branch), .exec_rdy(exec_rdy),
    .ifetch_en(ifetch_en), .dec_vld(dec_vld), .dec_op(dec_op),
    .dec_reg(dec_reg), .dec_mode(dec_mode), .dec_imm(dec_imm),
    .dec_addr(dec_addr), .dec_pc(dec_pc), .dec_next_pc(dec_next_pc),
    .dec_illegal(dec_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic [AW-1:0] pc);
    inst_i   = b;
    fetch_pc = pc;
    inst_vld = 1'b1;
    cyc();
    inst_vld = 1'b0;
  endtask

  function automatic exp_t mk(input logic [7:0] b0, input logic [7:0] imm,
                              input logic [AW-1:0] addr, input logic [AW-1:0] pc,
                              input logic [AW-1:0] npc);
    exp_t e;
    e.op   = b0[7:4];
    e.rsel = b0[3:2];
    e.mode = b0[1:0];
    e.imm  = imm;
    e.addr = addr;
    e.pc   = pc;
    e.npc  = npc;
    e.ill  = (b0[1:0] == 2'b11);
    return e;
  endfunction

  // Monitor: an instruction is retired when execute takes it without a flush.
  always @(negedge clk) begin
    if (reset_ && dec_vld && exec_rdy && !branch) begin
      exp_t act;
      exp_t e;
      act = {dec_op, dec_reg, dec_mode, dec_imm, dec_addr, dec_pc, dec_next_pc, dec_illegal};
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL dec_unexpected got %0h expected none", act);
      end else begin
        e = sb.pop_front();
        if (act !== e) begin
          errors++;
          $display("FAIL dec_out got %0h expected %0h", act, e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset and idle
    #12;
    chk("rst_vld", dec_vld, 0);
    chk("rst_ifetch_en", ifetch_en, 1);
    chk("rst_fields", {dec_op, dec_reg, dec_mode, dec_imm, dec_addr, dec_pc, dec_next_pc, dec_illegal}, 0);
    cyc();
    reset_ = 1'b1;
    cyc(); cyc();
    chk("idle_vld", dec_vld, 0);
    chk("idle_ifetch_en", ifetch_en, 1);

    // absolute instruction
    exec_rdy = 1'b1;
    sb.push_back(mk(8'h5A, 8'h00, 12'h234, 12'h100, 12'h103));
    send(8'h5A, 12'h100);
    send(8'h34, 12'h101);
    chk("abs_not_yet_vld", dec_vld, 0);
    send(8'h02, 12'h102);
    chk("abs_vld_latency", dec_vld, 1);
    cyc();
    chk("abs_retired", dec_vld, 0);

    // immediate stalled in HOLD, implied at the wrap address
    exec_rdy = 1'b0;
    sb.push_back(mk(8'h11, 8'hAB, 12'h000, 12'hFFD, 12'hFFF));
    sb.push_back(mk(8'h20, 8'h00, 12'h000, 12'hFFF, 12'h000));
    send(8'h11, 12'hFFD);
    send(8'hAB, 12'hFFE);
    inst_i = 8'h20; fetch_pc = 12'hFFF; inst_vld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("stall_ifetch_en", ifetch_en, 0);
      chk("stall_vld", dec_vld, 1);
      chk("stall_imm", dec_imm, 8'hAB);
      cyc();
    end
    exec_rdy = 1'b1;
    #1;
    chk("release_ifetch_en", ifetch_en, 1);
    cyc();
    inst_vld = 1'b0;
    chk("wrap_vld", dec_vld, 1);
    cyc();

    // flush during OPR2
    send(8'h5A, 12'h200);
    send(8'h34, 12'h201);
    branch = 1'b1; inst_i = 8'h02; fetch_pc = 12'h202; inst_vld = 1'b1;
    cyc();
    branch = 1'b0; inst_vld = 1'b0;
    chk("flush_no_vld", dec_vld, 0);
    cyc();
    chk("flush_no_vld2", dec_vld, 0);
    sb.push_back(mk(8'h03, 8'h00, 12'h000, 12'h300, 12'h301));
    send(8'h03, 12'h300);
    chk("illegal_flag", dec_illegal, 1);
    cyc();

    // flush wins over exec_rdy on a held instruction
    exec_rdy = 1'b0;
    send(8'h40, 12'h400);
    exec_rdy = 1'b1; branch = 1'b1;
    cyc();
    branch = 1'b0;
    chk("flush_drop_held", dec_vld, 0);

    // asynchronous reset while in OPR1
    send(8'h11, 12'h010);
    #2;
    reset_ = 1'b0;
    #1;
    chk("async_rst_vld", dec_vld, 0);
    chk("async_rst_pc", dec_pc, 0);
    chk("async_rst_npc", dec_next_pc, 0);
    chk("async_rst_ifetch_en", ifetch_en, 1);
    cyc();
    reset_ = 1'b1;
    sb.push_back(mk(8'h40, 8'h00, 12'h000, 12'h050, 12'h051));
    send(8'h40, 12'h050);
    chk("post_rst_mode", dec_mode, 2'b00);
    cyc();

    // back-to-back implied stream
    sb.push_back(mk(8'h00, 8'h00, 12'h000, 12'h060, 12'h061));
    sb.push_back(mk(8'h10, 8'h00, 12'h000, 12'h061, 12'h062));
    sb.push_back(mk(8'h20, 8'h00, 12'h000, 12'h062, 12'h063));
    send(8'h00, 12'h060);
    chk("b2b_vld0", dec_vld, 1);
    send(8'h10, 12'h061);
    chk("b2b_vld1", dec_vld, 1);
    send(8'h20, 12'h062);
    chk("b2b_vld2", dec_vld, 1);
    cyc();
    cyc();

    chk("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
